// File: rtl/uart_tx.sv
// 8N1 UART transmitter: latches a byte on request while idle and shifts it out
// LSB first at CLK_GOAL clock cycles per bit, with registered line/busy/done outputs.
module uart_tx #(
  parameter int CLK_F    = 50_000_000,
  parameter int UART_BPS = 115200,
  parameter int CLK_GOAL = CLK_F / UART_BPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_txd,
  output logic       uart_tx_busy,
  output logic       uart_tx_done
);

  localparam int unsigned CNT_W = ($clog2(CLK_GOAL) > 16) ? $clog2(CLK_GOAL) : 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_GOAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (clk_cnt_q == CNT_LAST);

  // Outputs are registered, so the next line level is computed one cycle ahead
  // of the state it belongs to (e.g. shift_q[1] while shifting).
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    txd_d     = txd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        txd_d     = 1'b1;
        busy_d    = 1'b0;
        if (uart_tx_en) begin
          shift_d = uart_tx_data;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          txd_d     = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            txd_d     = 1'b1;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          txd_d     = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        clk_cnt_d = '0;
        txd_d     = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign uart_tx_done = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts one 8-bit byte per start request and shifts it out on `uart_txd` as an 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit) at `UART_BPS`. It is the transmit half of the course-design UART and sits beside the receiver, sharing its clock, reset and baud parameters, so a `uart_txd` → `uart_rxd` loopback reproduces the sent byte.

## Interface
- `CLK_F`, 50_000_000, system clock frequency in Hz.
- `UART_BPS`, 115200, baud rate.
- `CLK_GOAL`, `CLK_F / UART_BPS` (integer division, truncating), clock cycles per bit. Must be ≥ 2.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `uart_tx_en`  input  1  start request; sampled only while IDLE.
- `uart_tx_data`  input  8  byte to send; captured on the accepting edge.
- `uart_txd`  output  1  serial line; idles high.
- `uart_tx_busy`  output  1  high from the cycle after acceptance through the last stop-bit cycle.
- `uart_tx_done`  output  1  one-cycle pulse after the stop bit completes.

## Operation
- Reset (`rst_n` low at a rising edge): state IDLE, `uart_txd`=1, `uart_tx_busy`=0, `uart_tx_done`=0, shift register 0, bit counter 0, clock counter 0. Applies in any state. A frame in progress is abandoned and the line returns high at that edge.
- States:
  - IDLE: `uart_txd`=1. On `uart_tx_en`=1, latch `uart_tx_data` → START.
  - START: `uart_txd`=0 for `CLK_GOAL` cycles → DATA.
  - DATA: `uart_txd` = shift[0]. After each `CLK_GOAL` cycles, shift right by 1. After 8 bits → STOP.
  - STOP: `uart_txd`=1 for `CLK_GOAL` cycles → IDLE, pulsing `uart_tx_done`.
- Clock counter: 0 to `CLK_GOAL`-1, cleared on every bit boundary and in IDLE, at least 16 bits wide. Bit counter: 0 to 7, 3–4 bits wide.
- `uart_tx_en` outside IDLE is ignored. The request is neither queued nor does it corrupt the latched byte. Changes to `uart_tx_data` after acceptance have no effect.
- `uart_txd`, `uart_tx_busy` and `uart_tx_done` are registered. No combinational path from inputs to outputs.

## Timing
- Let edge E be the rising edge that accepts the request (IDLE and `uart_tx_en`=1). Write G for `CLK_GOAL`. Cycles are numbered from E, where cycle 1 is the cycle after E.
- Start bit: `uart_txd`=0 in cycles 1..G.
- Data bit k (k=0..7): cycles (k+1)G+1 .. (k+2)G.
- Stop bit: cycles 9G+1 .. 10G.
- `uart_tx_busy`=1 in cycles 1..10G.
- Cycle 10G+1: IDLE, `uart_txd`=1, `uart_tx_busy`=0, `uart_tx_done`=1 for exactly this one cycle.
- `uart_tx_en` high during cycle 10G+1 is accepted at the end of that cycle. The next start bit begins at cycle 10G+2. Minimum inter-frame gap is therefore 1 idle-high cycle beyond the stop bit.
- `uart_tx_en` held high continuously produces back-to-back frames with that 1-cycle gap.
- Total frame length 10G cycles. Baud error comes from truncation in G and is accepted.

## Test plan
All scenarios use `CLK_F`=1000, `UART_BPS`=100 (G=10) unless stated.
- Reset/idle: hold `rst_n`=0 for 3 cycles, then release with `uart_tx_en`=0 for 50 cycles → `uart_txd`=1, busy=0, done=0 throughout.
- Single byte 0xA5: one-cycle `uart_tx_en` → `uart_txd` is 0 for cycles 1–10, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then 1 for cycles 91–100. busy=1 in cycles 1–100. done=1 only in cycle 101.
- Ignore while busy: start 0x55, pulse `uart_tx_en` with `uart_tx_data`=0xFF at cycle 40 → frame still carries 0x55. No second frame follows. Exactly one done pulse.
- Back-to-back: hold `uart_tx_en`=1 with data 0x00, then 0xFF → second start bit begins at cycle 102. Each frame is bit-exact. Two done pulses, 101 cycles apart.
- Reset mid-frame: assert `rst_n`=0 at cycle 35 of a 0x00 frame → `uart_txd`=1 and busy=0 after that edge, no done pulse. A new 0x3C frame after release is bit-exact.
- Loopback with the receiver at default parameters (G=434): send 0x00, 0xFF, 0x5A, 0xC3 back-to-back → receiver `uart_data_out` matches each byte, with one `uart_done` per frame.
